// File: rtl/player_pkg.sv
// Shared types and default geometry for the player movement sequencer.
package player_pkg;

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_ERASE, S_DRAW} state_t;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int STEP_DEF   = 10;
  localparam int X_MIN_DEF  = 0;
  localparam int X_MAX_DEF  = 630;
  localparam int Y_MIN_DEF  = 0;
  localparam int Y_MAX_DEF  = 470;
  localparam int X_INIT_DEF = 320;
  localparam int Y_INIT_DEF = 240;
  localparam int REPEAT_DEF = 4;

endpackage

// File: rtl/player_step_calc.sv
// Combinational next-position calculator with direction priority and
// saturation at the playfield limits.
module player_step_calc
  import player_pkg::*;
#(
  parameter int STEP  = STEP_DEF,
  parameter int X_MIN = X_MIN_DEF,
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MIN = Y_MIN_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic [X_W-1:0] pos_x,
  input  logic [Y_W-1:0] pos_y,
  input  logic           left,
  input  logic           right,
  input  logic           up,
  input  logic           down,
  output logic [X_W-1:0] tgt_x,
  output logic [Y_W-1:0] tgt_y
);

  // One bit of headroom below zero so a step past the edge cannot wrap.
  localparam int C_W = 11;
  localparam logic signed [C_W-1:0] STEP_S  = C_W'(STEP);
  localparam logic signed [C_W-1:0] X_MIN_S = C_W'(X_MIN);
  localparam logic signed [C_W-1:0] X_MAX_S = C_W'(X_MAX);
  localparam logic signed [C_W-1:0] Y_MIN_S = C_W'(Y_MIN);
  localparam logic signed [C_W-1:0] Y_MAX_S = C_W'(Y_MAX);

  logic signed [C_W-1:0] px_s, py_s, nx_s, ny_s;

  always_comb begin
    px_s = {1'b0, pos_x};
    py_s = {2'b00, pos_y};
    nx_s = px_s;
    ny_s = py_s;
    if (left) begin
      nx_s = px_s - STEP_S;
      if (nx_s < X_MIN_S) nx_s = X_MIN_S;
    end else if (right) begin
      nx_s = px_s + STEP_S;
      if (nx_s > X_MAX_S) nx_s = X_MAX_S;
    end
    if (up) begin
      ny_s = py_s - STEP_S;
      if (ny_s < Y_MIN_S) ny_s = Y_MIN_S;
    end else if (down) begin
      ny_s = py_s + STEP_S;
      if (ny_s > Y_MAX_S) ny_s = Y_MAX_S;
    end
    tgt_x = nx_s[X_W-1:0];
    tgt_y = ny_s[Y_W-1:0];
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player position owner: frame-rate sampled moves with auto-repeat and a
// two-phase erase/draw request to the renderer over req/ack.
module player_move_ctrl
  import player_pkg::*;
#(
  parameter int STEP          = STEP_DEF,
  parameter int X_MIN         = X_MIN_DEF,
  parameter int X_MAX         = X_MAX_DEF,
  parameter int Y_MIN         = Y_MIN_DEF,
  parameter int Y_MAX         = Y_MAX_DEF,
  parameter int X_INIT        = X_INIT_DEF,
  parameter int Y_INIT        = Y_INIT_DEF,
  parameter int REPEAT_FRAMES = REPEAT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           left,
  input  logic           right,
  input  logic           up,
  input  logic           down,
  input  logic           respawn,
  output logic           draw_req,
  output logic           draw_erase,
  output logic [X_W-1:0] draw_x,
  output logic [Y_W-1:0] draw_y,
  input  logic           draw_ack,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           busy
);

  localparam int RC_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [X_W-1:0]  X_INIT_V = X_W'(X_INIT);
  localparam logic [Y_W-1:0]  Y_INIT_V = Y_W'(Y_INIT);
  localparam logic [RC_W-1:0] RC_LOAD  = RC_W'(REPEAT_FRAMES - 1);

  state_t          state;
  logic [RC_W-1:0] repeat_cnt;
  logic            respawn_pend;
  logic [X_W-1:0]  tgt_x, calc_x, cand_x;
  logic [Y_W-1:0]  tgt_y, calc_y, cand_y;
  logic            tgt_resp, cand_resp, cand_move, any_dir;

  player_step_calc #(
    .STEP (STEP),
    .X_MIN(X_MIN),
    .X_MAX(X_MAX),
    .Y_MIN(Y_MIN),
    .Y_MAX(Y_MAX)
  ) u_step (
    .pos_x(pos_x),
    .pos_y(pos_y),
    .left (left),
    .right(right),
    .up   (up),
    .down (down),
    .tgt_x(calc_x),
    .tgt_y(calc_y)
  );

  // Candidate target for a frame tick taken in S_IDLE; a pending respawn wins.
  always_comb begin
    any_dir   = left | right | up | down;
    cand_x    = pos_x;
    cand_y    = pos_y;
    cand_resp = 1'b0;
    if (respawn_pend) begin
      cand_x    = X_INIT_V;
      cand_y    = Y_INIT_V;
      cand_resp = 1'b1;
    end else if (any_dir && repeat_cnt == '0) begin
      cand_x = calc_x;
      cand_y = calc_y;
    end
    cand_move = (cand_x != pos_x) || (cand_y != pos_y);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_BOOT;
      draw_req     <= 1'b0;
      draw_erase   <= 1'b0;
      draw_x       <= X_INIT_V;
      draw_y       <= Y_INIT_V;
      pos_x        <= X_INIT_V;
      pos_y        <= Y_INIT_V;
      repeat_cnt   <= '0;
      respawn_pend <= 1'b0;
      tgt_resp     <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          if (draw_req && draw_ack) begin
            draw_req <= 1'b0;
            state    <= S_IDLE;
          end else begin
            draw_req   <= 1'b1;
            draw_erase <= 1'b0;
            draw_x     <= X_INIT_V;
            draw_y     <= Y_INIT_V;
          end
        end
        S_IDLE: begin
          if (frame_tick) begin
            if (!respawn_pend) begin
              if (!any_dir)               repeat_cnt <= '0;
              else if (repeat_cnt == '0)  repeat_cnt <= RC_LOAD;
              else                        repeat_cnt <= repeat_cnt - RC_W'(1);
            end
            if (cand_move) begin
              state      <= S_ERASE;
              tgt_x      <= cand_x;
              tgt_y      <= cand_y;
              tgt_resp   <= cand_resp;
              draw_req   <= 1'b1;
              draw_erase <= 1'b1;
              draw_x     <= pos_x;
              draw_y     <= pos_y;
            end else begin
              respawn_pend <= 1'b0;
            end
          end
        end
        S_ERASE: begin
          if (draw_req && draw_ack) begin
            draw_req <= 1'b0;
            state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          // Entered with draw_req low, which gives the mandatory gap cycle.
          if (draw_req && draw_ack) begin
            draw_req <= 1'b0;
            pos_x    <= tgt_x;
            pos_y    <= tgt_y;
            if (tgt_resp) respawn_pend <= 1'b0;
            state    <= S_IDLE;
          end else if (!draw_req) begin
            draw_req   <= 1'b1;
            draw_erase <= 1'b0;
            draw_x     <= tgt_x;
            draw_y     <= tgt_y;
          end
        end
        default: state <= S_BOOT;
      endcase
      // A new respawn request always survives a same-cycle clear.
      if (respawn) respawn_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: vector table plus hand-written
// sequences for saturation, dropped ticks, respawn and mid-request reset.
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic       respawn = 1'b0;
  logic       draw_ack = 1'b0;
  logic       draw_req, draw_erase, busy;
  logic [9:0] draw_x, pos_x;
  logic [8:0] draw_y, pos_y;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit l, r, u, d;
    bit mv;
    int px, py;
    int nx, ny;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  player_move_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .left      (left),
    .right     (right),
    .up        (up),
    .down      (down),
    .respawn   (respawn),
    .draw_req  (draw_req),
    .draw_erase(draw_erase),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .draw_ack  (draw_ack),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .busy      (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int req_pk();
    return int'(draw_erase) * 1000000 + int'(draw_x) * 1000 + int'(draw_y);
  endfunction

  function automatic int pos_pk();
    return int'(pos_x) * 1000 + int'(pos_y);
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!draw_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, int'(draw_req), 1);
  endtask

  // pulse: 0 none, 1 frame_tick, 2 respawn, asserted while the request waits
  task automatic serve(input bit e, input int x, input int y, input int delay,
                       input int pulse, input string tag);
    int snap;
    bit stable;
    wait_req(tag);
    check({tag, "_data"}, req_pk(), int'(e) * 1000000 + x * 1000 + y);
    snap   = req_pk();
    stable = 1'b1;
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && pulse == 1) frame_tick = 1'b1;
      if (i == 0 && pulse == 2) respawn = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      respawn    = 1'b0;
      if (!draw_req || req_pk() != snap) stable = 1'b0;
    end
    if (delay > 0) check({tag, "_stable"}, int'(stable), 1);
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack = 1'b0;
    check({tag, "_req_drop"}, int'(draw_req), 0);
  endtask

  task automatic tick_dirs(input bit l, input bit r, input bit u, input bit d, input string tag);
    wait_idle(tag);
    left = l; right = r; up = u; down = d;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic expect_move(input bit l, input bit r, input bit u, input bit d,
                             input int px, input int py, input int nx, input int ny,
                             input string tag);
    tick_dirs(l, r, u, d, tag);
    serve(1'b1, px, py, 1, 0, {tag, "_erase"});
    serve(1'b0, nx, ny, 0, 0, {tag, "_draw"});
    check({tag, "_pos"}, pos_pk(), nx * 1000 + ny);
  endtask

  task automatic expect_none(input bit l, input bit r, input bit u, input bit d,
                             input int px, input int py, input string tag);
    bit seen = 1'b0;
    tick_dirs(l, r, u, d, tag);
    repeat (6) begin
      if (draw_req) seen = 1'b1;
      @(negedge clk);
    end
    check({tag, "_noreq"}, int'(seen), 0);
    check({tag, "_pos"}, pos_pk(), px * 1000 + py);
  endtask

  initial begin
    int x, y;
    // table: l r u d mv  px py  nx ny   (starts at 320,240 with counter clear)
    tbl.push_back('{0,1,0,0, 1, 320,240, 330,240});
    tbl.push_back('{0,0,0,0, 0, 330,240,   0,  0});
    tbl.push_back('{1,1,0,0, 1, 330,240, 320,240});
    tbl.push_back('{0,0,0,0, 0, 320,240,   0,  0});
    tbl.push_back('{0,0,0,1, 1, 320,240, 320,250});
    tbl.push_back('{0,0,0,0, 0, 320,250,   0,  0});
    tbl.push_back('{0,0,1,1, 1, 320,250, 320,240});
    tbl.push_back('{0,0,0,0, 0, 320,240,   0,  0});
    tbl.push_back('{0,1,1,0, 1, 320,240, 330,230});
    tbl.push_back('{0,1,1,0, 0, 330,230,   0,  0});
    tbl.push_back('{0,1,1,0, 0, 330,230,   0,  0});
    tbl.push_back('{0,1,1,0, 0, 330,230,   0,  0});
    tbl.push_back('{0,1,1,0, 1, 330,230, 340,220});
    tbl.push_back('{0,1,1,0, 0, 340,220,   0,  0});
    tbl.push_back('{0,1,1,0, 0, 340,220,   0,  0});
    tbl.push_back('{0,1,1,0, 0, 340,220,   0,  0});
    tbl.push_back('{0,1,1,0, 1, 340,220, 350,210});
    tbl.push_back('{0,0,0,0, 0, 350,210,   0,  0});

    // reset state and boot draw
    repeat (3) @(negedge clk);
    check("rst_req", int'(draw_req), 0);
    check("rst_pos", pos_pk(), 320240);
    check("rst_draw", req_pk(), 320240);
    check("rst_busy", int'(busy), 1);
    reset = 1'b0;
    serve(1'b0, 320, 240, 3, 0, "boot");
    check("boot_busy", int'(busy), 0);
    check("boot_pos", pos_pk(), 320240);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].mv)
        expect_move(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d,
                    tbl[i].px, tbl[i].py, tbl[i].nx, tbl[i].ny, $sformatf("vec%0d", i));
      else
        expect_none(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d,
                    tbl[i].px, tbl[i].py, $sformatf("vec%0d", i));
    end

    // a tick arriving while busy must not advance the repeat counter
    tick_dirs(0, 1, 0, 0, "drop");
    serve(1'b1, 350, 210, 2, 1, "drop_erase");
    serve(1'b0, 360, 210, 0, 0, "drop_draw");
    check("drop_pos", pos_pk(), 360210);
    expect_none(0, 1, 0, 0, 360, 210, "drop_r2");
    expect_none(0, 1, 0, 0, 360, 210, "drop_r3");
    expect_none(0, 1, 0, 0, 360, 210, "drop_r4");
    expect_move(0, 1, 0, 0, 360, 210, 370, 210, "drop_r5");
    expect_none(0, 0, 0, 0, 370, 210, "drop_rel");

    // walk to the left edge; a tick at x=0 issues no request
    x = 370;
    while (x > 0) begin
      expect_move(1, 0, 0, 0, x, 210, x - 10, 210, $sformatf("left%0d", x));
      expect_none(0, 0, 0, 0, x - 10, 210, $sformatf("left_rel%0d", x));
      x -= 10;
    end
    expect_none(1, 0, 0, 0, 0, 210, "left_edge");
    expect_none(0, 0, 0, 0, 0, 210, "left_edge_rel");

    y = 210;
    while (y > 0) begin
      expect_move(0, 0, 1, 0, 0, y, 0, y - 10, $sformatf("up%0d", y));
      expect_none(0, 0, 0, 0, 0, y - 10, $sformatf("up_rel%0d", y));
      y -= 10;
    end
    expect_none(1, 0, 1, 0, 0, 0, "corner");
    expect_none(0, 0, 0, 0, 0, 0, "corner_rel");

    // respawn during S_DRAW: the move commits first, the respawn follows
    tick_dirs(0, 1, 0, 0, "t5");
    serve(1'b1, 0, 0, 1, 0, "t5_erase");
    serve(1'b0, 10, 0, 2, 2, "t5_draw");
    check("t5_pos", pos_pk(), 10000);
    expect_move(0, 0, 0, 0, 10, 0, 320, 240, "t5_resp");
    expect_none(0, 0, 0, 0, 320, 240, "t5_after");

    // ack with no request outstanding is ignored
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ack_busy", int'(busy), 0);
    check("stray_ack_req", int'(draw_req), 0);

    // respawn already at spawn point: no request, pending flag cleared
    respawn = 1'b1;
    @(negedge clk);
    respawn = 1'b0;
    expect_none(0, 0, 0, 0, 320, 240, "resp_same");
    expect_move(0, 1, 0, 0, 320, 240, 330, 240, "after_resp");
    expect_none(0, 0, 0, 0, 330, 240, "after_resp_rel");

    // reset while the erase request is outstanding
    tick_dirs(0, 1, 0, 0, "t6");
    wait_req("t6");
    check("t6_data", req_pk(), 1330240);
    reset = 1'b1;
    @(negedge clk);
    check("t6_req", int'(draw_req), 0);
    check("t6_pos", pos_pk(), 320240);
    check("t6_busy", int'(busy), 1);
    reset = 1'b0;
    right = 1'b0;
    serve(1'b0, 320, 240, 1, 0, "t6_boot");
    check("t6_idle", int'(busy), 0);
    check("t6_final_pos", pos_pk(), 320240);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
